// File: rtl/vdp_vga_timing.sv
// Raster timing for the VDP pipeline: 640x480@60 counters, syncs and window/border flags (optional VDP_TIMING_VBLANK_IRQ_EN adds vblank_tick/frame_ctr).
// Latency: every output registered with its coordinates, zero skew; no backpressure, free-running.
module vdp_vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int VID_COLS  = 512,
  parameter int VID_ROWS  = 384
) (
  input  logic       pxclk,
  input  logic       reset,
  output logic [9:0] px_col,
  output logic [9:0] px_row,
  output logic       hsync,
  output logic       vsync,
  output logic       vid_active,
  output logic       vid_active0,
  output logic       bdr_active,
  output logic       last_pixel,
  output logic       col_last,
  output logic       row_last
`ifdef VDP_TIMING_VBLANK_IRQ_EN
  ,
  output logic       vblank_tick,
  output logic [7:0] frame_ctr
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_BDR   = (H_VISIBLE - VID_COLS) / 2;
  localparam int V_BDR   = (V_VISIBLE - VID_ROWS) / 2;

  // The fetch/render FSM relies on these alignments; refuse to build otherwise.
  if ((H_TOTAL % 2) != 0 || (H_BDR % 2) != 0 || (V_BDR % 16) != 0 ||
      H_TOTAL > 1024 || V_TOTAL > 1024 || VID_COLS > H_VISIBLE || VID_ROWS > V_VISIBLE) begin : g_bad_cfg
    $error("vdp_vga_timing: needs even H_TOTAL, even H_BDR, V_BDR multiple of 16, totals <= 1024");
  end

  localparam logic [9:0] COL_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] ROW_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_LO   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_HI   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_HI   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] VC_LO   = 10'(H_BDR);
  localparam logic [9:0] VC_HI   = 10'(H_BDR + VID_COLS - 1);
  localparam logic [9:0] VR_LO   = 10'(V_BDR);
  localparam logic [9:0] VR_HI   = 10'(V_BDR + VID_ROWS - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);

  function automatic logic in_vid(input logic [9:0] c, input logic [9:0] r);
    return (c >= VC_LO) && (c <= VC_HI) && (r >= VR_LO) && (r <= VR_HI);
  endfunction

  function automatic logic in_bdr(input logic [9:0] c, input logic [9:0] r);
    return (c < H_VIS) && (r < V_VIS) && !in_vid(c, r);
  endfunction

  logic [9:0] col_nx, row_nx, col_nx2, row_nx2;

  // Coordinates one and two clocks ahead; flags are evaluated on these and registered.
  always_comb begin
    col_nx  = (px_col == COL_MAX) ? 10'd0 : px_col + 10'd1;
    row_nx  = px_row;
    if (px_col == COL_MAX) row_nx = (px_row == ROW_MAX) ? 10'd0 : px_row + 10'd1;
    col_nx2 = (col_nx == COL_MAX) ? 10'd0 : col_nx + 10'd1;
    row_nx2 = row_nx;
    if (col_nx == COL_MAX) row_nx2 = (row_nx == ROW_MAX) ? 10'd0 : row_nx + 10'd1;
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      px_col      <= 10'd0;
      px_row      <= 10'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      vid_active  <= in_vid(10'd0, 10'd0);
      vid_active0 <= in_vid(10'd1, 10'd0);
      bdr_active  <= in_bdr(10'd0, 10'd0);
      last_pixel  <= 1'b0;
      col_last    <= 1'b0;
      row_last    <= 1'b0;
    end else begin
      px_col      <= col_nx;
      px_row      <= row_nx;
      hsync       <= (col_nx >= HS_LO) && (col_nx <= HS_HI);
      vsync       <= (row_nx >= VS_LO) && (row_nx <= VS_HI);
      vid_active  <= in_vid(col_nx, row_nx);
      vid_active0 <= in_vid(col_nx2, row_nx2);
      bdr_active  <= in_bdr(col_nx, row_nx);
      last_pixel  <= (col_nx == COL_MAX) && (row_nx == ROW_MAX);
      col_last    <= (col_nx == COL_MAX);
      row_last    <= (row_nx == ROW_MAX);
    end
  end

`ifdef VDP_TIMING_VBLANK_IRQ_EN
  // Tick marks the final pixel of the VDP window's last line.
  always_ff @(posedge pxclk) begin
    if (reset) begin
      vblank_tick <= 1'b0;
      frame_ctr   <= 8'd0;
    end else begin
      vblank_tick <= (col_nx == COL_MAX) && (row_nx == VR_HI);
      if (last_pixel) frame_ctr <= frame_ctr + 8'd1;
    end
  end
`else
  // Without the interrupt option there is no frame-level state at all.
`endif

endmodule

// File: tb/tb_vdp_vga_timing.sv
// Scoreboarded bench: full-size raster plus a shrunken raster that wraps many frames under random resets.
module tb_vdp_vga_timing;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic hs, vs, vid, vid0, bdr, lp, cl, rl;
`ifdef VDP_TIMING_VBLANK_IRQ_EN
    logic vbt;
    logic [7:0] fc;
`endif
  } obs_t;

  typedef struct {
    int hv, hfp, hs, hbp, vv, vfp, vs, vbp, vc, vr;
  } geom_t;

  localparam int N_CYC = 41500;

  geom_t gd, gs;
  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_s;
  obs_t got_d, got_s;
  obs_t q_d[$];
  obs_t q_s[$];

  vdp_vga_timing dut_d (
    .pxclk(clk), .reset(rst_d),
    .px_col(got_d.col), .px_row(got_d.row), .hsync(got_d.hs), .vsync(got_d.vs),
    .vid_active(got_d.vid), .vid_active0(got_d.vid0), .bdr_active(got_d.bdr),
    .last_pixel(got_d.lp), .col_last(got_d.cl), .row_last(got_d.rl)
`ifdef VDP_TIMING_VBLANK_IRQ_EN
    , .vblank_tick(got_d.vbt), .frame_ctr(got_d.fc)
`endif
  );

  vdp_vga_timing #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VISIBLE(40), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .VID_COLS(8), .VID_ROWS(8)
  ) dut_s (
    .pxclk(clk), .reset(rst_s),
    .px_col(got_s.col), .px_row(got_s.row), .hsync(got_s.hs), .vsync(got_s.vs),
    .vid_active(got_s.vid), .vid_active0(got_s.vid0), .bdr_active(got_s.bdr),
    .last_pixel(got_s.lp), .col_last(got_s.cl), .row_last(got_s.rl)
`ifdef VDP_TIMING_VBLANK_IRQ_EN
    , .vblank_tick(got_s.vbt), .frame_ctr(got_s.fc)
`endif
  );

  function automatic bit in_win(geom_t g, int c, int r);
    int hb = (g.hv - g.vc) / 2;
    int vb = (g.vv - g.vr) / 2;
    return c >= hb && c < hb + g.vc && r >= vb && r < vb + g.vr;
  endfunction

  // Expected outputs when the raster is t clocks past the (0,0) reset state.
  function automatic obs_t model(geom_t g, int t);
    obs_t o;
    int ht = g.hv + g.hfp + g.hs + g.hbp;
    int vt = g.vv + g.vfp + g.vs + g.vbp;
    int f  = ht * vt;
    int u  = t % f;
    int c  = u % ht;
    int r  = u / ht;
    int u1 = (u + 1) % f;
    o.col  = 10'(c);
    o.row  = 10'(r);
    o.hs   = c >= g.hv + g.hfp && c < g.hv + g.hfp + g.hs;
    o.vs   = r >= g.vv + g.vfp && r < g.vv + g.vfp + g.vs;
    o.vid  = in_win(g, c, r);
    o.vid0 = in_win(g, u1 % ht, u1 / ht);
    o.bdr  = c < g.hv && r < g.vv && !o.vid;
    o.cl   = c == ht - 1;
    o.rl   = r == vt - 1;
    o.lp   = o.cl && o.rl;
`ifdef VDP_TIMING_VBLANK_IRQ_EN
    o.vbt  = o.cl && r == (g.vv - g.vr) / 2 + g.vr - 1;
    o.fc   = 8'((t / f) % 256);
`endif
    return o;
  endfunction

  task automatic check(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Stimulus: drive resets, push the state each edge must produce.
  int t_d, t_s, cyc;
  bit mid_done;
  initial begin
    gd = '{hv:640, hfp:16, hs:96, hbp:48, vv:480, vfp:10, vs:2, vbp:33, vc:512, vr:384};
    gs = '{hv:16, hfp:2, hs:4, hbp:2, vv:40, vfp:2, vs:2, vbp:2, vc:8, vr:8};
    rst_d = 1'b1;
    rst_s = 1'b1;
    t_d = 0;
    t_s = 0;
    mid_done = 1'b0;
    for (int n = 0; n < N_CYC; n++) begin
      @(posedge clk);
      cyc = n;
      t_d = rst_d ? 0 : t_d + 1;
      t_s = rst_s ? 0 : t_s + 1;
      q_d.push_back(model(gd, t_d));
      q_s.push_back(model(gs, t_s));
      #1;
      rst_d = (n < 3);
      // One-clock reset while the full raster sits at (300,1).
      if (!mid_done && t_d == 800 + 300) begin
        rst_d = 1'b1;
        mid_done = 1'b1;
      end
      rst_s = (n < 3) || ($urandom_range(0, 1499) == 0);
    end
    @(negedge clk);
    #1;
    check("mid_reset_issued", cyc, 64'(mid_done), 64'd1);
    check("first_vid_col", cyc, 64'(first_vid_c), 64'd64);
    check("first_vid_row", cyc, 64'(first_vid_r), 64'd48);
    check("first_vid0_col", cyc, 64'(first_vid0_c), 64'd63);
    check("first_vid0_row", cyc, 64'(first_vid0_r), 64'd48);
    check("line_wraps_seen", cyc, 64'(lines_d > 40), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: pop the expectation for every presented state and compare.
  obs_t e;
  int hs_cnt = 0;
  int lines_d = 0;
  int first_vid_c = -1, first_vid_r = -1, first_vid0_c = -1, first_vid0_r = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        check("raster_640x480", cyc, 64'(got_d), 64'(e));
        check("vid_bdr_exclusive", cyc, 64'(got_d.vid & got_d.bdr), 64'd0);
        if (got_d.col == 10'd0) hs_cnt = 0;
        hs_cnt += int'(got_d.hs);
        if (got_d.cl) begin
          lines_d++;
          check("hsync_width", cyc, 64'(hs_cnt), 64'd96);
        end
        if (got_d.vid && first_vid_c < 0) begin
          first_vid_c = int'(got_d.col);
          first_vid_r = int'(got_d.row);
        end
        if (got_d.vid0 && first_vid0_c < 0) begin
          first_vid0_c = int'(got_d.col);
          first_vid0_r = int'(got_d.row);
        end
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        check("raster_small", cyc, 64'(got_s), 64'(e));
      end
    end
  end

endmodule
